citron_bus_arbiter: RTL and testbench

- Shares the single Citron device bus (UART, SimDebug and future devices) between NUM_REQ requesters, e.g. the AXI slave bridge and a debug/DMA master.
- Round-robin arbitration; sequences each transaction as issue, stall-wait, then response.
- Drives citron_addr/rdy/wr/writedata; consumes the OR-reduced citron_readdata/stall/match.

---
 rtl/citron_bus_arbiter_if.sv | 36 +++
 rtl/citron_bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_citron_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/citron_bus_arbiter_if.sv
// Citron bus arbiter signal bundle: requester handshakes, responses and device bus.
// Latency: none, wires only. Backpressure: req_ready_o per requester; responses cannot be stalled.
// slave = arbiter side, master = requesters/devices side.
interface citron_bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ-1:0]    req_wr_i;
    logic [8*NUM_REQ-1:0]  req_addr_i;
    logic [32*NUM_REQ-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]    resp_valid_o;
    logic [31:0]           resp_rdata_o;
    logic                  resp_err_o;
    logic [7:0]            citron_addr_o;
    logic                  citron_rdy_o;
    logic                  citron_wr_o;
    logic [31:0]           citron_writedata_o;
    logic [31:0]           citron_readdata_i;
    logic                  citron_stall_i;
    logic                  citron_match_i;

    modport slave (
        input  req_valid_i, req_wr_i, req_addr_i, req_wdata_i,
        input  citron_readdata_i, citron_stall_i, citron_match_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output citron_addr_o, citron_rdy_o, citron_wr_o, citron_writedata_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_addr_i, req_wdata_i,
        output citron_readdata_i, citron_stall_i, citron_match_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  citron_addr_o, citron_rdy_o, citron_wr_o, citron_writedata_o
    );
endinterface

// File: rtl/citron_bus_arbiter.sv
// Round-robin arbiter sharing the Citron device bus; optional stall timeout via CITRON_ARB_TIMEOUT_EN.
// Latency: handshake T, bus strobe T+1, response T+3 plus stall cycles; next grant from T+4.
// Backpressure: one transaction in flight, req_ready_o only in IDLE; responses cannot be stalled.
module citron_bus_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int STALL_TIMEOUT = 255
) (
    input logic                clk_i,
    input logic                rst_n,
    citron_bus_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || STALL_TIMEOUT < 1) begin : g_bad_param
        $error("citron_bus_arbiter: unsupported parameter values");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [7:0]           addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 rdy_q, rdy_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic [IW-1:0]        pick;
    logic                 pick_vld;
    logic [IW:0]          sum;
    logic [7:0]           addr_sel;
    logic                 wr_sel;
    logic [31:0]          wdata_sel;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [NUM_REQ-1:0]   rr_oh;

`ifdef CITRON_ARB_TIMEOUT_EN
    localparam int CW = $clog2(STALL_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Walk from farthest to nearest so the first valid after rr wins.
    always_comb begin
        pick     = rr_q;
        pick_vld = 1'b0;
        sum      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, rr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sum[IW-1:0] == IW'(i) && bus.req_valid_i[i]) begin
                    pick     = IW'(i);
                    pick_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        addr_sel  = '0;
        wr_sel    = 1'b0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i)) begin
                addr_sel  = bus.req_addr_i[i*8 +: 8];
                wr_sel    = bus.req_wr_i[i];
                wdata_sel = bus.req_wdata_i[i*32 +: 32];
            end
        end
    end

    assign pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
    assign rr_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << rr_q;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        rdy_d        = 1'b0;
        resp_valid_d = '0;
        rdata_d      = '0;
        err_d        = 1'b0;
`ifdef CITRON_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    rr_d    = pick;
                    addr_d  = addr_sel;
                    wr_d    = wr_sel;
                    wdata_d = wdata_sel;
                    rdy_d   = 1'b1;
                    state_d = ISSUE;
`ifdef CITRON_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Devices never stall writes, so a write completes on its first WAIT cycle.
                if (wr_q || !bus.citron_stall_i) begin
                    rdata_d      = wr_q ? 32'h0 : bus.citron_readdata_i;
                    err_d        = ~bus.citron_match_i;
                    resp_valid_d = rr_oh;
                    addr_d       = '0;
                    wr_d         = 1'b0;
                    state_d      = RESP;
                end
`ifdef CITRON_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(STALL_TIMEOUT - 1)) begin
                    err_d        = 1'b1;
                    resp_valid_d = rr_oh;
                    addr_d       = '0;
                    wr_d         = 1'b0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= IW'(NUM_REQ - 1);
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            rdy_q        <= 1'b0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
`ifdef CITRON_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            rdy_q        <= rdy_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef CITRON_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Ready is gated by reset so nothing is accepted while the block is held in reset.
    assign bus.req_ready_o        = (rst_n && state_q == IDLE && pick_vld) ? pick_oh : '0;
    assign bus.resp_valid_o       = resp_valid_q;
    assign bus.resp_rdata_o       = rdata_q;
    assign bus.resp_err_o         = err_q;
    assign bus.citron_addr_o      = addr_q;
    assign bus.citron_rdy_o       = rdy_q;
    assign bus.citron_wr_o        = wr_q;
    assign bus.citron_writedata_o = wdata_q;
endmodule

// File: tb/tb_citron_bus_arbiter.sv
// Directed bench for citron_bus_arbiter (2 requesters, STALL_TIMEOUT=4).
// Inputs change on the falling edge; outputs are checked there, half a cycle after the rising edge.
module tb_citron_bus_arbiter;
    logic clk_i = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    citron_bus_arbiter_if #(.NUM_REQ(2)) bus ();

    citron_bus_arbiter #(.NUM_REQ(2), .STALL_TIMEOUT(4)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raises a single request at a falling edge, checks its immediate grant and
    // returns at the falling edge of cycle T+1 with the request withdrawn.
    task automatic start_req(input int idx, input logic wr, input logic [7:0] a,
                             input logic [31:0] d, input string tag);
        @(negedge clk_i);
        if (idx == 0) begin
            bus.req_addr_i  = {bus.req_addr_i[15:8], a};
            bus.req_wdata_i = {bus.req_wdata_i[63:32], d};
            bus.req_wr_i    = {bus.req_wr_i[1], wr};
        end else begin
            bus.req_addr_i  = {a, bus.req_addr_i[7:0]};
            bus.req_wdata_i = {d, bus.req_wdata_i[31:0]};
            bus.req_wr_i    = {wr, bus.req_wr_i[0]};
        end
        bus.req_valid_i = 2'b01 << idx;
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'(1) << idx);
        @(negedge clk_i);
        bus.req_valid_i = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int rdy_cnt;
        int seen;
        int n;
        logic [1:0] fair_oh [6];
        int fair_t [6];

        rst_n                 = 1'b0;
        bus.req_valid_i       = 2'b01;
        bus.req_wr_i          = 2'b00;
        bus.req_addr_i        = '0;
        bus.req_wdata_i       = '0;
        bus.citron_readdata_i = '0;
        bus.citron_stall_i    = 1'b0;
        bus.citron_match_i    = 1'b0;
        #1;
        chk("reset_ready", 32'(bus.req_ready_o), 32'h0);
        chk("reset_rdy", 32'(bus.citron_rdy_o), 32'h0);
        chk("reset_addr", 32'(bus.citron_addr_o), 32'h0);
        chk("reset_resp", 32'(bus.resp_valid_o), 32'h0);
        bus.req_valid_i = 2'b00;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;

        // Single read, no stall
        bus.citron_readdata_i = 32'hDEADBEEF;
        bus.citron_match_i    = 1'b1;
        start_req(0, 1'b0, 8'h01, 32'h0, "rd");
        chk("rd_rdy_t1", 32'(bus.citron_rdy_o), 32'h1);
        chk("rd_addr_t1", 32'(bus.citron_addr_o), 32'h01);
        chk("rd_wr_t1", 32'(bus.citron_wr_o), 32'h0);
        chk("rd_resp_t1", 32'(bus.resp_valid_o), 32'h0);
        @(negedge clk_i);
        chk("rd_rdy_t2", 32'(bus.citron_rdy_o), 32'h0);
        chk("rd_addr_t2", 32'(bus.citron_addr_o), 32'h01);
        @(negedge clk_i);
        chk("rd_resp_t3", 32'(bus.resp_valid_o), 32'h1);
        chk("rd_rdata", bus.resp_rdata_o, 32'hDEADBEEF);
        chk("rd_err", 32'(bus.resp_err_o), 32'h0);
        chk("rd_addr_clr", 32'(bus.citron_addr_o), 32'h0);
        @(negedge clk_i);
        chk("rd_resp_pulse", 32'(bus.resp_valid_o), 32'h0);

        // Read stalled for five WAIT cycles
        bus.citron_readdata_i = 32'hCAFEF00D;
        start_req(0, 1'b0, 8'h22, 32'h0, "st");
        rdy_cnt = int'(bus.citron_rdy_o);
        bus.citron_stall_i = 1'b1;
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk_i);
            rdy_cnt += int'(bus.citron_rdy_o);
            chk("st_addr_hold", 32'(bus.citron_addr_o), 32'h22);
            chk("st_no_resp", 32'(bus.resp_valid_o), 32'h0);
            if (k == 7) bus.citron_stall_i = 1'b0;
        end
        @(negedge clk_i);
        chk("st_resp_t8", 32'(bus.resp_valid_o), 32'h1);
        chk("st_rdata", bus.resp_rdata_o, 32'hCAFEF00D);
        chk("st_err", 32'(bus.resp_err_o), 32'h0);
        chk("st_rdy_pulses", 32'(rdy_cnt), 32'h1);
        @(negedge clk_i);

        // Unmapped read
        bus.citron_readdata_i = 32'h0;
        bus.citron_match_i    = 1'b0;
        start_req(0, 1'b0, 8'hF0, 32'h0, "um");
        @(negedge clk_i);
        @(negedge clk_i);
        chk("um_resp", 32'(bus.resp_valid_o), 32'h1);
        chk("um_err", 32'(bus.resp_err_o), 32'h1);
        chk("um_rdata", bus.resp_rdata_o, 32'h0);
        @(negedge clk_i);

        // Write from requester 1, then an unmatched write
        bus.citron_match_i = 1'b1;
        start_req(1, 1'b1, 8'h10, 32'h55, "wr");
        chk("wr_rdy_t1", 32'(bus.citron_rdy_o), 32'h1);
        chk("wr_wr_t1", 32'(bus.citron_wr_o), 32'h1);
        chk("wr_wdata_t1", bus.citron_writedata_o, 32'h55);
        chk("wr_addr_t1", 32'(bus.citron_addr_o), 32'h10);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("wr_resp_t3", 32'(bus.resp_valid_o), 32'h2);
        chk("wr_err", 32'(bus.resp_err_o), 32'h0);
        chk("wr_wr_clr", 32'(bus.citron_wr_o), 32'h0);
        @(negedge clk_i);
        bus.citron_match_i = 1'b0;
        start_req(1, 1'b1, 8'h11, 32'hAA, "wrnm");
        @(negedge clk_i);
        @(negedge clk_i);
        chk("wrnm_resp", 32'(bus.resp_valid_o), 32'h2);
        chk("wrnm_err", 32'(bus.resp_err_o), 32'h1);
        @(negedge clk_i);

        // Fairness with both requesters held
        bus.citron_match_i = 1'b1;
        bus.req_wr_i       = 2'b00;
        bus.req_addr_i     = {8'hA1, 8'hA0};
        bus.req_valid_i    = 2'b11;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            #1;
            if (bus.req_ready_o != 2'b00) begin
                fair_oh[n] = bus.req_ready_o;
                fair_t[n]  = c;
                n++;
            end
            @(negedge clk_i);
        end
        bus.req_valid_i = 2'b00;
        chk("fair_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < n) chk("fair_grant", 32'(fair_oh[i]), 32'(1) << (i % 2));
            if (i > 0 && i < n) chk("fair_gap", 32'(fair_t[i] - fair_t[i-1]), 32'd4);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);

        // Reset in the middle of a stalled read
        bus.citron_readdata_i = 32'h12345678;
        start_req(0, 1'b0, 8'h33, 32'h77, "rst");
        bus.citron_stall_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        bus.req_valid_i = 2'b01;
        rst_n = 1'b0;
        #1;
        chk("rst_addr", 32'(bus.citron_addr_o), 32'h0);
        chk("rst_rdy", 32'(bus.citron_rdy_o), 32'h0);
        chk("rst_wr", 32'(bus.citron_wr_o), 32'h0);
        chk("rst_wdata", bus.citron_writedata_o, 32'h0);
        chk("rst_resp", 32'(bus.resp_valid_o), 32'h0);
        chk("rst_rdata", bus.resp_rdata_o, 32'h0);
        chk("rst_err", 32'(bus.resp_err_o), 32'h0);
        chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
        bus.req_valid_i    = 2'b00;
        bus.citron_stall_i = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (bus.resp_valid_o != 2'b00) seen++;
        end
        chk("rst_no_resp", 32'(seen), 32'h0);
        bus.req_valid_i = 2'b11;
        #1;
        chk("rst_next_grant", 32'(bus.req_ready_o), 32'h1);
        @(negedge clk_i);
        bus.req_valid_i = 2'b00;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_after_resp", 32'(bus.resp_valid_o), 32'h1);
        @(negedge clk_i);

        // Stall held high
        bus.citron_readdata_i = 32'hBAD0BAD0;
        start_req(0, 1'b0, 8'h44, 32'h0, "to");
        bus.citron_stall_i = 1'b1;
`ifdef CITRON_ARB_TIMEOUT_EN
        seen = 0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk_i);
            if (bus.resp_valid_o != 2'b00) seen++;
        end
        chk("to_no_early_resp", 32'(seen), 32'h0);
        @(negedge clk_i);
        chk("to_resp", 32'(bus.resp_valid_o), 32'h1);
        chk("to_err", 32'(bus.resp_err_o), 32'h1);
        chk("to_rdata", bus.resp_rdata_o, 32'h0);
        bus.citron_stall_i = 1'b0;
        @(negedge clk_i);
`else
        seen = 0;
        for (int k = 2; k <= 21; k++) begin
            @(negedge clk_i);
            if (bus.resp_valid_o != 2'b00) seen++;
            if (k == 21) bus.citron_stall_i = 1'b0;
        end
        chk("to_no_resp", 32'(seen), 32'h0);
        chk("to_addr_hold", 32'(bus.citron_addr_o), 32'h44);
        @(negedge clk_i);
        chk("to_release_resp", 32'(bus.resp_valid_o), 32'h1);
        chk("to_release_rdata", bus.resp_rdata_o, 32'hBAD0BAD0);
        @(negedge clk_i);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
